// File: rtl/barret_reduce_pipe.sv
// Three-stage Barrett reduction of an unsigned operand modulo Q.
// A tag travels with each operand; one global enable stalls the whole pipe.
module barret_reduce_pipe #(
  parameter int Q     = 3257,
  parameter int W_Q   = 12,
  parameter int W_IN  = 23,
  parameter int W_TAG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_IN-1:0]  din_a,
  input  logic [W_TAG-1:0] din_tag,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W_Q-1:0]   dout_r,
  output logic [W_TAG-1:0] dout_tag,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [15:0]      ops_cnt
);

  localparam int K  = 2 * W_Q;
  localparam int PW = W_IN + K + 1;
  localparam int RW = W_Q + 2;

  localparam longint unsigned M_L = (64'd1 << K) / Q;
  localparam logic [PW-1:0] M_P = PW'(M_L);
  localparam logic [RW-1:0] Q1 = RW'(Q);
  localparam logic [RW-1:0] Q2 = RW'(2 * Q);

  if ((Q % 2) == 0 || Q <= 2 ||
      Q >= (1 << W_Q) || Q < (1 << (W_Q - 1)) ||
      W_IN > 2 * W_Q || W_TAG < 1) begin : g_bad_param
    $error("barret_reduce_pipe: illegal parameter set");
  end

  logic             v1_q, v2_q, v3_q;
  logic [W_TAG-1:0] t1_q, t2_q, t3_q;
  logic [W_IN-1:0]  a1_q;
  logic [PW-1:0]    p1_q, p1_d;
  logic [RW-1:0]    r2_q, r2_d;
  logic [W_Q-1:0]   r3_q, r3_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             en;

  assign en         = !v3_q | dout_ready;
  assign din_ready  = en;
  assign dout_valid = v3_q;
  assign dout_r     = r3_q;
  assign dout_tag   = t3_q;
  assign ops_cnt    = cnt_q;

  // Datapath: product, estimated remainder, final correction.
  always_comb begin
    p1_d = PW'(din_a) * M_P;
    r2_d = RW'(a1_q) - RW'(p1_q >> K) * Q1;
    r3_d = W_Q'(r2_q);
    if (r2_q >= Q2) begin
      r3_d = W_Q'(r2_q - Q2);
    end else if (r2_q >= Q1) begin
      r3_d = W_Q'(r2_q - Q1);
    end
  end

  // Output transfer counter, wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (v3_q && dout_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Pipeline registers advance together whenever the output can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
      a1_q <= '0;
      p1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else if (en) begin
      v1_q <= din_valid;
      t1_q <= din_tag;
      a1_q <= din_a;
      p1_q <= p1_d;
      v2_q <= v1_q;
      t2_q <= t1_q;
      r2_q <= r2_d;
      v3_q <= v2_q;
      t3_q <= t2_q;
      r3_q <= r3_d;
    end
  end

  // Completed-transfer count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// Directed and scoreboarded checks for barret_reduce_pipe.
// Default parameters: Q = 3257, W_Q = 12, W_IN = 23, W_TAG = 4.
module tb_barret_reduce_pipe;

  localparam int QM = 3257;

  logic        clk;
  logic        rst_n;
  logic [22:0] din_a;
  logic [3:0]  din_tag;
  logic        din_valid;
  logic        din_ready;
  logic [11:0] dout_r;
  logic [3:0]  dout_tag;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] ops_cnt;

  int n_chk;
  int n_fail;
  int exp_ops;

  barret_reduce_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_a     (din_a),
    .din_tag   (din_tag),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout_r    (dout_r),
    .dout_tag  (dout_tag),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .ops_cnt   (ops_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1;
    din_valid = 1'b0;
    din_a = '0;
    din_tag = '0;
    dout_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %b want 0", dout_valid);
    end
    n_chk++;
    if (ops_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_cnt got %0d want 0", ops_cnt);
    end
    n_chk++;
    if (dout_r !== 12'd0 || dout_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_data got r=%0d t=%0d want 0 0",
               dout_r, dout_tag);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got %b want 1", din_ready);
    end
    exp_ops = 0;
  endtask

  task automatic test_stream();
    int n;
    logic [11:0] er;
    logic [3:0] et;
    n = QM;
    dout_ready = 1'b1;
    for (int k = 0; k < n + 3; k++) begin
      @(posedge clk);
      #1;
      if (k >= 3) begin
        er = 12'(k - 3);
        et = 4'(k - 3);
        n_chk++;
        if (dout_valid !== 1'b1 || dout_r !== er ||
            dout_tag !== et) begin
          n_fail++;
          $display("FAIL stream[%0d] got v=%b r=%0d t=%0d want 1 %0d %0d",
                   k - 3, dout_valid, dout_r, dout_tag, er, et);
        end
      end else begin
        n_chk++;
        if (dout_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_lat%0d got v=%b want 0", k, dout_valid);
        end
      end
      if (k < n) begin
        din_valid = 1'b1;
        din_a = 23'(k);
        din_tag = 4'(k);
      end else begin
        din_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    exp_ops += n;
    n_chk++;
    if (dout_valid !== 1'b0 || ops_cnt !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL stream_end got v=%b cnt=%0d want 0 %0d",
               dout_valid, ops_cnt, exp_ops);
    end
  endtask

  logic [22:0] va[8] = '{23'd3257, 23'd6513, 23'd6514, 23'd8388607,
                         23'd0, 23'd3256, 23'd9771, 23'd4194304};
  logic [11:0] vr[8] = '{12'd0, 12'd3256, 12'd0, 12'd1832,
                         12'd0, 12'd3256, 12'd0, 12'd2545};

  task automatic test_vectors();
    logic [3:0] et;
    dout_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      #1;
      if (k >= 3) begin
        et = 4'(k + 5);
        n_chk++;
        if (dout_valid !== 1'b1 || dout_r !== vr[k-3] ||
            dout_tag !== et) begin
          n_fail++;
          $display("FAIL vec a=%0d got v=%b r=%0d t=%0d want 1 %0d %0d",
                   va[k-3], dout_valid, dout_r, dout_tag, vr[k-3], et);
        end
      end
      if (k < 8) begin
        din_valid = 1'b1;
        din_a = va[k];
        din_tag = 4'(k + 8);
      end else begin
        din_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    exp_ops += 8;
    n_chk++;
    if (ops_cnt !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL vec_cnt got %0d want %0d", ops_cnt, exp_ops);
    end
  endtask

  task automatic test_stall();
    logic [22:0] sa[3];
    logic [11:0] sr[3];
    sa = '{23'd100, 23'd5000, 23'd9000};
    sr = '{12'd100, 12'd1743, 12'd2486};
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      din_valid = 1'b1;
      din_a = sa[k];
      din_tag = 4'(k + 5);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin
        @(posedge clk);
        #1;
      end
      n_chk++;
      if (dout_valid !== 1'b1 || dout_r !== sr[0] ||
          dout_tag !== 4'd5 || din_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d got v=%b r=%0d t=%0d rdy=%b want 1 %0d 5 0",
                 s, dout_valid, dout_r, dout_tag, din_ready, sr[0]);
      end
    end
    dout_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (dout_valid !== 1'b1 || dout_r !== sr[k] ||
          dout_tag !== 4'(k + 5)) begin
        n_fail++;
        $display("FAIL stall_rel%0d got v=%b r=%0d t=%0d want 1 %0d %0d",
                 k, dout_valid, dout_r, dout_tag, sr[k], k + 5);
      end
    end
    @(posedge clk);
    #1;
    exp_ops += 3;
    n_chk++;
    if (dout_valid !== 1'b0 || ops_cnt !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL stall_end got v=%b cnt=%0d want 0 %0d",
               dout_valid, ops_cnt, exp_ops);
    end
  endtask

  task automatic test_reset_inflight();
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      din_valid = 1'b1;
      din_a = 23'(k + 1);
      din_tag = 4'(k + 1);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_ops = 0;
    n_chk++;
    if (dout_valid !== 1'b0 || ops_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL inflight_rst got v=%b cnt=%0d want 0 0",
               dout_valid, ops_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale%0d got v=%b r=%0d want v=0",
                 k, dout_valid, dout_r);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] qr[$];
    logic [3:0] qt[$];
    logic [11:0] er;
    logic [3:0] et;
    logic [11:0] pr;
    logic [3:0] pt;
    logic hold;
    int xfers;
    int cyc;
    hold = 1'b0;
    pr = '0;
    pt = '0;
    xfers = 0;
    cyc = 0;
    while (xfers < 3000 && cyc < 30000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (hold) begin
        n_chk++;
        if (dout_valid !== 1'b1 || dout_r !== pr || dout_tag !== pt) begin
          n_fail++;
          $display("FAIL rnd_hold got v=%b r=%0d t=%0d want 1 %0d %0d",
                   dout_valid, dout_r, dout_tag, pr, pt);
        end
      end
      dout_ready = 1'($urandom_range(0, 3) != 0);
      din_valid = 1'($urandom_range(0, 1));
      din_a = 23'($urandom_range(0, 8388607));
      din_tag = 4'($urandom_range(0, 15));
      #1;
      hold = dout_valid && !dout_ready;
      pr = dout_r;
      pt = dout_tag;
      if (dout_valid && dout_ready) begin
        xfers++;
        er = (qr.size() > 0) ? qr.pop_front() : 12'hfff;
        et = (qt.size() > 0) ? qt.pop_front() : 4'hf;
        n_chk++;
        if (dout_r !== er || dout_tag !== et) begin
          n_fail++;
          $display("FAIL rnd[%0d] got r=%0d t=%0d want %0d %0d",
                   xfers, dout_r, dout_tag, er, et);
        end
      end
      if (din_valid && din_ready) begin
        qr.push_back(12'(int'(din_a) % QM));
        qt.push_back(din_tag);
      end
    end
    n_chk++;
    if (xfers < 3000) begin
      n_fail++;
      $display("FAIL rnd_budget got %0d transfers want 3000", xfers);
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        xfers++;
        er = (qr.size() > 0) ? qr.pop_front() : 12'hfff;
        et = (qt.size() > 0) ? qt.pop_front() : 4'hf;
        n_chk++;
        if (dout_r !== er || dout_tag !== et) begin
          n_fail++;
          $display("FAIL rnd_drain got r=%0d t=%0d want %0d %0d",
                   dout_r, dout_tag, er, et);
        end
      end
    end
    exp_ops += xfers;
    n_chk++;
    if (qr.size() != 0 || ops_cnt !== 16'(exp_ops)) begin
      n_fail++;
      $display("FAIL rnd_cnt got cnt=%0d left=%0d want %0d 0",
               ops_cnt, qr.size(), exp_ops % 65536);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_ops = 0;
    test_reset();
    test_stream();
    test_vectors();
    test_stall();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
